isqrt_seq: RTL and testbench
============================

Name: isqrt_seq

Overview:
- Multicycle integer square-root stage that sits directly downstream of the x²+y² squaring/sum stage in the rectangular-to-cylindrical path.
- Consumes the 16-bit r_squared value over a valid/ready handshake.
- Produces the 8-bit magnitude r plus its remainder, using a digit-by-digit (restoring) algorithm at one result bit per clock.
- Replaces a purely combinational square root with a small, timing-friendly sequential unit.

Parameters:
- OUT_W, 8, root width in bits; operand width is 2*OUT_W; remainder width is OUT_W+1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand present on in_data.
- in_ready  output  1  stage can accept an operand.
- in_data  input  2*OUT_W  unsigned operand (r_squared).
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- out_root  output  OUT_W  floor(sqrt(in_data)), or the rounded value (see Optional Feature).
- out_rem  output  OUT_W+1  in_data − floor_root².
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, out_root=0, out_rem=0, busy=0, internal operand/count cleared. Reset is asynchronous and may occur in any state; the in-flight operation is discarded and no result is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture in_data into the operand shift register, clear partial root and remainder, set count=0, go to CALC.
  - With in_valid=0: stay in IDLE.
- CALC:
  - in_ready=0.
  - Each edge performs one iteration:
    - rem' = (rem<<2) | operand[MSB:MSB-1]
    - operand <<= 2
    - trial = (root<<2) | 1
    - if rem' >= trial: rem = rem' − trial, root = (root<<1)|1
    - else: rem = rem', root = root<<1
    - count++
  - Intermediate rem/trial are held at OUT_W+2 bits. No truncation is permitted; the final rem fits in OUT_W+1 bits (max 2*root).
  - After the OUT_W-th iteration, register out_root/out_rem and go to DONE.
- DONE:
  - out_valid=1.
  - out_root and out_rem are stable until the handshake completes.
  - On an edge with out_ready=1: out_valid drops and the state returns to IDLE.
  - Backpressure (out_ready=0) holds DONE indefinitely.
- Latency: out_valid rises exactly OUT_W cycles after the accepting edge (8 cycles by default).
- Throughput: one result per OUT_W+2 cycles minimum, when in_valid and out_ready are held high.
- in_data is sampled only on the accepting edge; later changes do not affect the result.
- in_valid during CALC/DONE is ignored (not accepted). The upstream stage must hold it until in_ready.
- Boundaries:
  - 0 gives root 0, rem 0.
  - Max operand 2^(2*OUT_W)−1 gives root 2^OUT_W−1, rem 2^(OUT_W+1)−2.
  - Perfect squares give rem 0.
- out_root/out_rem retain the last result after leaving DONE. They are only updated on entry to DONE.

Optional Feature:
- Macro: ISQRT_ROUND_EN.
- Defined:
  - out_root is rounded to nearest: floor_root+1 when final rem > floor_root, otherwise floor_root.
  - The result saturates at 2^OUT_W−1. For example, 65535 gives 255, not 256.
  - The rounding compare/increment is applied in the same edge that enters DONE, so latency is unchanged.
  - out_rem still reports in_data − floor_root².
- Undefined: out_root = floor_root; no rounding logic is present.

Test Plan:
- Reset: assert rst_n=0 then release -> in_ready=1, out_valid=0, out_root=0, out_rem=0, busy=0.
- Basic: in_data=25 (x=3,y=4), out_ready=1 -> out_valid exactly 8 cycles after accept, out_root=5, out_rem=0; in_data=0 -> root 0, rem 0.
- Extremes:
  - in_data=65535 -> root 255, rem 510 (with ISQRT_ROUND_EN: 255, saturated).
  - in_data=24 -> root 4, rem 8 (with ISQRT_ROUND_EN: 5).
  - in_data=20 -> root 4, rem 4 (4 with ISQRT_ROUND_EN).
- Backpressure: out_ready=0 for 20 cycles after out_valid -> outputs stable, in_ready=0, in_valid ignored. Raising out_ready -> one handshake, then in_ready=1 next cycle.
- Back-to-back: stream 1,2,...,300 with in_valid and out_ready always high -> results equal floor(sqrt(n)) in order, one per 10 cycles, no drops or duplicates.
- Reset mid-operation: pulse rst_n low during CALC iteration 4 -> immediate IDLE, out_valid never asserts for that operand. Next operand 144 -> root 12, rem 0.

Source files
------------

// File: rtl/isqrt_seq.sv
// ---------------------------------------------------------------------------
// isqrt_seq
// Multicycle integer square root. It follows the x^2+y^2 squaring/sum stage
// in the rectangular-to-cylindrical path. It takes a 2*OUT_W-bit r_squared
// operand and returns the OUT_W-bit magnitude r and the remainder. It uses a
// restoring digit-by-digit algorithm that resolves one root bit per clock.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand present on in_data
//   in_ready   unit idle and able to accept an operand
//   in_data    unsigned operand (2*OUT_W bits)
//   out_valid  result present on out_root/out_rem
//   out_ready  downstream accepts the result
//   out_root   floor(sqrt(in_data)), rounded to nearest when enabled
//   out_rem    in_data - floor_root^2 (OUT_W+1 bits)
//   busy       high while computing or holding a result
//
// Build option:
//   ISQRT_ROUND_EN  when defined, out_root is rounded to nearest and
//                   saturates at 2^OUT_W-1. out_rem always reports the
//                   floor remainder.
// ---------------------------------------------------------------------------
module isqrt_seq #(
  parameter int OUT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*OUT_W-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_root,
  output logic [OUT_W:0]       out_rem,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OUT_W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_reg, state_next;
  logic [2*OUT_W-1:0]   op_reg, op_next;
  logic [OUT_W-1:0]     root_reg, root_next;
  logic [OUT_W+1:0]     rem_reg, rem_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [OUT_W-1:0]     out_root_reg, out_root_next;
  logic [OUT_W:0]       out_rem_reg, out_rem_next;

  // One restoring iteration. The partial remainder never exceeds twice the
  // partial root, so OUT_W+2 bits hold rem' and trial without loss.
  logic [OUT_W+1:0]     rem_shift;
  logic [OUT_W+1:0]     trial;
  logic                 take;
  logic [OUT_W+1:0]     iter_rem;
  logic [OUT_W-1:0]     iter_root;
  logic [OUT_W-1:0]     final_root;

  assign rem_shift = (rem_reg << 2) | {{OUT_W{1'b0}}, op_reg[2*OUT_W-1 -: 2]};
  assign trial     = ({2'b00, root_reg} << 2) | {{(OUT_W+1){1'b0}}, 1'b1};
  assign take      = (rem_shift >= trial);
  assign iter_rem  = take ? (rem_shift - trial) : rem_shift;
  assign iter_root = (root_reg << 1) | {{(OUT_W-1){1'b0}}, take};

`ifdef ISQRT_ROUND_EN
  // Round up when rem > root, because (r+0.5)^2 = r^2 + r + 0.25. The
  // all-ones root cannot be incremented, so it saturates.
  assign final_root = ((iter_rem > {2'b00, iter_root}) && (iter_root != '1))
                      ? (iter_root + OUT_W'(1)) : iter_root;
`else
  assign final_root = iter_root;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      op_reg       <= '0;
      root_reg     <= '0;
      rem_reg      <= '0;
      cnt_reg      <= '0;
      out_root_reg <= '0;
      out_rem_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      root_reg     <= root_next;
      rem_reg      <= rem_next;
      cnt_reg      <= cnt_next;
      out_root_reg <= out_root_next;
      out_rem_reg  <= out_rem_next;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    root_next     = root_reg;
    rem_next      = rem_reg;
    cnt_next      = cnt_reg;
    out_root_next = out_root_reg;
    out_rem_next  = out_rem_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          op_next    = in_data;
          root_next  = '0;
          rem_next   = '0;
          cnt_next   = '0;
          state_next = CALC;
        end
      end
      CALC: begin
        op_next   = op_reg << 2;
        root_next = iter_root;
        rem_next  = iter_rem;
        cnt_next  = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(OUT_W - 1)) begin
          // The last iteration goes straight into the output registers,
          // so the result appears OUT_W edges after the accept.
          out_root_next = final_root;
          out_rem_next  = iter_rem[OUT_W:0];
          state_next    = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign out_root  = out_root_reg;
  assign out_rem   = out_rem_reg;

endmodule

// File: tb/tb_isqrt_seq.sv
// ---------------------------------------------------------------------------
// tb_isqrt_seq
// Directed self-checking bench for isqrt_seq (OUT_W = 8). It covers:
//   - reset values
//   - latency
//   - boundary operands
//   - backpressure
//   - a back-to-back stream
//   - a reset asserted in the middle of an operation
// It honours ISQRT_ROUND_EN when that macro is defined.
// ---------------------------------------------------------------------------
module tb_isqrt_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*W-1:0] in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_root;
  logic [W:0]     out_rem;
  logic           busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  isqrt_seq #(.OUT_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_root  (out_root),
    .out_rem   (out_rem),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Expected root as presented on out_root, given the floor root and remainder.
  function automatic int exp_root(input int fl, input int rem);
`ifdef ISQRT_ROUND_EN
    if (rem > fl && fl < 255) return fl + 1;
    return fl;
`else
    return fl + 0 * rem;
`endif
  endfunction

  // Reference floor square root by linear search.
  function automatic int ref_sqrt(input int n);
    int r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one operand with out_ready high, then check latency and result.
  task automatic run_op(input int data, input int fl, input int rem);
    int lat = 0;
    out_ready = 1'b1;
    in_data   = data[2*W-1:0];
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk($sformatf("latency(%0d)", data), lat, W);
    chk($sformatf("root(%0d)", data), int'(out_root), exp_root(fl, rem));
    chk($sformatf("rem(%0d)", data), int'(out_rem), rem);
    $display("op in=%0d root=%0d rem=%0d lat=%0d", data, out_root, out_rem, lat);
    tick();
    chk("in_ready_after_hs", int'(in_ready), 1);
  endtask

  typedef struct { int d; int r; int m; } vec_t;
  vec_t vecs[12] = '{
    '{25, 5, 0}, '{0, 0, 0}, '{65535, 255, 510}, '{24, 4, 8},
    '{20, 4, 4}, '{1, 1, 0}, '{2, 1, 1}, '{3, 1, 2},
    '{4, 2, 0}, '{144, 12, 0}, '{65025, 255, 0}, '{65024, 254, 508}
  };

  initial begin
    int t;
    int last_cyc;
    logic seen;

    // Reset state
    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_root", int'(out_root), 0);
    chk("rst_rem", int'(out_rem), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed vectors
    foreach (vecs[i]) run_op(vecs[i].d, vecs[i].r, vecs[i].m);

    // Backpressure: hold the result for 20 cycles while in_valid is driven
    out_ready = 1'b0;
    in_data   = 16'd100;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 40) begin tick(); t++; end
    chk("bp_reach_done", int'(out_valid), 1);
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_data  = 16'd9999;
      tick();
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_root", int'(out_root), 10);
      chk("bp_rem", int'(out_rem), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_hs_valid", int'(out_valid), 0);
    chk("bp_hs_in_ready", int'(in_ready), 1);
    chk("bp_retain_root", int'(out_root), 10);
    $display("backpressure root=%0d rem=%0d held 20 cycles", out_root, out_rem);
    tick();
    chk("bp_single_hs", int'(busy), 0);

    // Back-to-back stream 1..300
    in_valid  = 1'b1;
    out_ready = 1'b1;
    last_cyc  = -1;
    for (int n = 1; n <= 300; n++) begin
      int fl;
      in_data = n[2*W-1:0];
      t = 0;
      while (!in_ready && t < 20) begin tick(); t++; end
      tick();
      t = 0;
      while (!out_valid && t < 40) begin tick(); t++; end
      fl = ref_sqrt(n);
      chk($sformatf("b2b_root(%0d)", n), int'(out_root), exp_root(fl, n - fl * fl));
      chk($sformatf("b2b_rem(%0d)", n), int'(out_rem), n - fl * fl);
      if (last_cyc >= 0) chk($sformatf("b2b_period(%0d)", n), cyc - last_cyc, W + 2);
      last_cyc = cyc;
      $display("b2b in=%0d root=%0d rem=%0d", n, out_root, out_rem);
    end
    in_valid = 1'b0;
    tick();
    tick();

    // Reset in the middle of CALC, before iteration 4
    in_data  = 16'd50000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_root", int'(out_root), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("mid_rst_no_result", int'(seen), 0);
    $display("mid-op reset: result suppressed=%0d", !seen);
    run_op(144, 12, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
